// File: rtl/pipe_pkg.sv
// Shared types for the execute-stage controller: forwarding selects,
// multi-cycle FSM states, the pipeline slot record and hazard helpers.
package pipe_pkg;

  localparam int unsigned PIPE_RA_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // One record for all slots; MEM ignores multi, WB ignores load and multi.
  typedef struct packed {
    logic                 v;
    logic [PIPE_RA_W-1:0] rd;
    logic                 wen;
    logic                 load;
    logic                 multi;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{
    v:     1'b0,
    rd:    {PIPE_RA_W{1'b0}},
    wen:   1'b0,
    load:  1'b0,
    multi: 1'b0
  };

  function automatic logic slot_hit(input slot_t s, input logic [PIPE_RA_W-1:0] rs);
    return s.v && s.wen && (s.rd == rs) && (rs != {PIPE_RA_W{1'b0}});
  endfunction

  // Youngest writer wins: EX is checked before MEM.
  function automatic fwd_e fwd_pick(input slot_t ex, input slot_t mem,
                                    input logic [PIPE_RA_W-1:0] rs, input logic used);
    fwd_e sel;
    if (!used) begin
      sel = FWD_RF;
    end else if (slot_hit(ex, rs)) begin
      sel = FWD_EXMEM;
    end else if (slot_hit(mem, rs)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_ctrl_if.sv
// Decode/execute control bundle between the decode stage (master) and
// the execute-stage controller (slave).
interface ex_ctrl_if
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = PIPE_RA_W
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_rf_w_en;
  logic                  id_is_load;
  logic                  id_is_multi;
  logic                  mem_ready;
  logic                  flush;

  logic                  id_ready;
  logic                  ex_advance;
  logic                  ex_valid;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;
  logic                  muldiv_start;
  logic                  muldiv_busy;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rf_w_en, id_is_load, id_is_multi, mem_ready, flush,
    input  id_ready, ex_advance, ex_valid, fwd_sel1, fwd_sel2,
           muldiv_start, muldiv_busy
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rf_w_en, id_is_load, id_is_multi, mem_ready, flush,
    output id_ready, ex_advance, ex_valid, fwd_sel1, fwd_sel2,
           muldiv_start, muldiv_busy
  );

endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle op sequencer: keeps EX held for MULDIV_LAT cycles and
// emits a one-cycle start pulse in the first cycle the op sits in EX.
module muldiv_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic flush,
  input  logic mem_ready,
  output logic hold,
  output logic busy,
  output logic start_pulse
);

  // Entry edge already counts as one cycle and DONE as another.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 32'd2);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q;

  // Sequencer state, counter and registered start pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      start_q <= 1'b0;
    end else begin
      start_q <= start & ~flush;
      if (flush) begin
        state_q <= MD_IDLE;
        cnt_q   <= {CNT_W{1'b0}};
      end else begin
        case (state_q)
          MD_IDLE: begin
            if (start) begin
              state_q <= MD_BUSY;
              cnt_q   <= CNT_LOAD;
            end else begin
              state_q <= MD_IDLE;
            end
          end
          MD_BUSY: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
              state_q <= MD_DONE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          MD_DONE: begin
            if (mem_ready && start) begin
              state_q <= MD_BUSY;
              cnt_q   <= CNT_LOAD;
            end else if (mem_ready) begin
              state_q <= MD_IDLE;
            end else begin
              state_q <= MD_DONE;
            end
          end
          default: begin
            state_q <= MD_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign hold        = (state_q == MD_BUSY) | ((state_q == MD_DONE) & ~mem_ready);
  assign busy        = (state_q != MD_IDLE);
  assign start_pulse = start_q;

endmodule

// File: rtl/ex_ctrl.sv
// Execute-stage controller: in-flight destination tracking, load-use/RAW stall,
// multi-cycle hold, EX/MEM enable and flush. Option macro: EX_CTRL_FWD_EN.
module ex_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = PIPE_RA_W,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic     clk,
  input  logic     reset,
  ex_ctrl_if.slave bus
);

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  slot_t                 ex_q, ex_d;
  slot_t                 mem_q, mem_d;
  slot_t                 wb_q, wb_d;
  slot_t                 id_slot;
  logic [1:0]            fwd1_q, fwd1_d;
  logic [1:0]            fwd2_q, fwd2_d;
  logic                  dep_stall;
  logic                  hold;
  logic                  ex_advance;
  logic                  id_ready;
  logic                  load_ex;
  logic                  md_start;
  logic                  md_busy;
  logic                  md_start_pulse;
  logic                  unused_slot_bits;

  assign rs1 = bus.id_rs1_addr;
  assign rs2 = bus.id_rs2_addr;

`ifdef EX_CTRL_FWD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign dep_stall = ex_q.load &
                     ((bus.id_rs1_used & slot_hit(ex_q, rs1)) |
                      (bus.id_rs2_used & slot_hit(ex_q, rs2)));
`else
  // Without forwarding, any pending writer blocks until it has left WB.
  assign dep_stall = (bus.id_rs1_used & (slot_hit(ex_q, rs1) | slot_hit(mem_q, rs1) |
                                         slot_hit(wb_q, rs1))) |
                     (bus.id_rs2_used & (slot_hit(ex_q, rs2) | slot_hit(mem_q, rs2) |
                                         slot_hit(wb_q, rs2)));
`endif

  assign ex_advance = bus.mem_ready & ~hold;
  assign id_ready   = ex_advance & ~dep_stall & ~bus.flush;
  assign load_ex    = bus.id_valid & id_ready;
  assign md_start   = load_ex & bus.id_is_multi;

  assign id_slot = '{
    v:     1'b1,
    rd:    bus.id_rd_addr,
    wen:   bus.id_rf_w_en,
    load:  bus.id_is_load,
    multi: bus.id_is_multi
  };

  // Next-state for the slot pipeline and the forwarding selects.
  always_comb begin
    ex_d   = ex_q;
    mem_d  = mem_q;
    wb_d   = wb_q;
    fwd1_d = fwd1_q;
    fwd2_d = fwd2_q;
    if (ex_advance) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (load_ex) begin
        ex_d = id_slot;
      end else begin
        ex_d = SLOT_EMPTY;
      end
    end else if (bus.flush) begin
      ex_d.v = 1'b0;
    end else begin
      ex_d = ex_q;
    end
`ifdef EX_CTRL_FWD_EN
    if (load_ex) begin
      fwd1_d = fwd_pick(ex_q, mem_q, rs1, bus.id_rs1_used);
      fwd2_d = fwd_pick(ex_q, mem_q, rs2, bus.id_rs2_used);
    end else begin
      fwd1_d = fwd1_q;
      fwd2_d = fwd2_q;
    end
`else
    fwd1_d = FWD_RF;
    fwd2_d = FWD_RF;
`endif
  end

  // Slot and forwarding-select registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q   <= SLOT_EMPTY;
      mem_q  <= SLOT_EMPTY;
      wb_q   <= SLOT_EMPTY;
      fwd1_q <= FWD_RF;
      fwd2_q <= FWD_RF;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  muldiv_seq #(
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) u_muldiv_seq (
    .clk         (clk),
    .reset       (reset),
    .start       (md_start),
    .flush       (bus.flush),
    .mem_ready   (bus.mem_ready),
    .hold        (hold),
    .busy        (md_busy),
    .start_pulse (md_start_pulse)
  );

  assign bus.id_ready     = id_ready;
  assign bus.ex_advance   = ex_advance;
  assign bus.ex_valid     = ex_q.v;
  assign bus.fwd_sel1     = fwd1_q;
  assign bus.fwd_sel2     = fwd2_q;
  assign bus.muldiv_start = md_start_pulse;
  assign bus.muldiv_busy  = md_busy;

  // Slot fields kept for traceability that no hazard term reads in this build.
  assign unused_slot_bits = ^{ex_q.load, ex_q.multi, mem_q.load, mem_q.multi, wb_q};

endmodule

// File: doc/ex_ctrl.md
Name: ex_ctrl

Overview:
- Execute-stage controller for the in-order pipeline.
- Tracks destination registers in flight across the EX, MEM and WB slots, and generates registered forwarding selects for both ALU operands.
- Stalls decode on load-use hazards and holds EX for the full duration of fixed-latency multi-cycle ops (mul/div).
- Drives the EX/MEM register enable and applies branch-redirect flushes.

Parameters:
- REG_ADDR_W, 5, register-address width.
- MULDIV_LAT, 4, EX occupancy in cycles of a multi-cycle op; legal range 2..255.
- CNT_W, 8, width of the multi-cycle counter; must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode presents an instruction.
- id_rs1_addr  in  REG_ADDR_W  source 1 address.
- id_rs2_addr  in  REG_ADDR_W  source 2 address.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd_addr  in  REG_ADDR_W  destination address.
- id_rf_w_en  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_is_multi  in  1  instruction is a multi-cycle op.
- mem_ready  in  1  MEM stage can accept; 0 freezes the EX, MEM and WB slots.
- flush  in  1  branch redirect.
- id_ready  out  1  decode transfer accepted this cycle.
- ex_advance  out  1  enable for the EX/MEM register.
- ex_valid  out  1  EX slot holds a live instruction.
- fwd_sel1  out  2  operand-1 source for the instruction in EX.
- fwd_sel2  out  2  operand-2 source for the instruction in EX.
- muldiv_start  out  1  one-cycle pulse when a multi op enters EX.
- muldiv_busy  out  1  multi FSM is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): all slots invalid, fwd_sel1/fwd_sel2=FWD_RF, FSM=IDLE, counter=0, muldiv_start=0. Combinational outputs follow from this state.
- Slots: EX {v, rd, wen, load, multi}, MEM {v, rd, wen, load}, WB {v, rd, wen}.
- hit(slot, rs): slot.v & slot.wen & slot.rd==rs & rs!=0. Register x0 never produces a hazard.
- load_use: EX.load & hit(EX, rs) for any used source of the ID instruction.
- hold: FSM=BUSY, or FSM=DONE & !mem_ready.
- ex_advance = mem_ready & !hold (combinational).
- id_ready = ex_advance & !load_use & !flush (combinational).
- On ex_advance:
  - EX moves to MEM, and MEM moves to WB.
  - EX loads the ID instruction if id_valid & id_ready; otherwise EX receives a bubble (v=0).
- On !ex_advance: all slots hold, except that flush still clears EX.v.
- Forwarding selects are registered and update only when the ID instruction is loaded into EX. They are evaluated per source against the pre-edge slots:
  - hit(EX) gives FWD_EXMEM.
  - else hit(MEM) gives FWD_MEMWB.
  - else FWD_RF.
  - EX takes priority over MEM (youngest writer wins).
  - An unused source gives FWD_RF.
- Load-use stall: exactly one bubble. The consumer then enters EX with FWD_MEMWB against the load.
- Multi FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when a multi instruction is loaded into EX. On that edge counter=MULDIV_LAT-2, and muldiv_start pulses in the following cycle.
  - BUSY: counter decrements each cycle; BUSY → DONE when counter==0.
  - DONE → IDLE when mem_ready=1 and the op leaves EX. A multi op entering EX on that same edge goes directly to BUSY.
  - With mem_ready held at 1, EX occupancy is exactly MULDIV_LAT cycles.
- flush:
  - Clears EX.v and blocks the ID transfer that cycle.
  - Forces FSM to IDLE and counter to 0.
  - MEM and WB advance normally if mem_ready=1.
  - Simultaneous flush and load_use: flush wins; no stall is recorded.
- Reset mid multi-op: FSM returns to IDLE immediately and no muldiv_start is emitted.

Optional Feature:
- EX_CTRL_FWD_EN defined: forwarding as specified above.
- EX_CTRL_FWD_EN undefined:
  - fwd_sel1 and fwd_sel2 are constant FWD_RF.
  - load_use is replaced by raw_stall: hit against the EX, MEM or WB slot for any used source.
  - Decode stalls until the writer has retired through WB.

Decomposition:
- Shared package pipe_pkg:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - MD_IDLE, MD_BUSY, MD_DONE state encodings.
  - Slot record typedef.
- One sub-module, muldiv_seq: FSM plus counter. Inputs start, flush, mem_ready; outputs hold, busy, start_pulse.

Test Plan:
- Back-to-back dependency: ADD x5 then SUB x6,x5,x1 with mem_ready=1 → no stall; SUB enters EX with fwd_sel1=01, fwd_sel2=00.
- Distance-2 dependency: ADD x5; NOP; OR x7,x1,x5 → fwd_sel2=10; writing x0 then reading x0 → fwd_sel=00.
- Load-use: LW x3 then ADD x4,x3,x3 → id_ready=0 for exactly 1 cycle with ex_valid=0 bubble; ADD then enters EX with fwd_sel1=fwd_sel2=10.
- MUL with MULDIV_LAT=4:
  - muldiv_start pulses once and ex_advance is low for 3 cycles.
  - A following dependent ADD enters EX with fwd_sel=01.
  - Repeat with mem_ready=0 in the DONE cycle → FSM holds DONE until mem_ready=1.
- Flush during BUSY at counter=1 → ex_valid=0 and FSM=IDLE next cycle; a new instruction is accepted the following cycle.
- Async reset asserted mid-cycle during BUSY → ex_valid=0, muldiv_busy=0 and fwd_sel=00 immediately, before the next clock edge.
- With EX_CTRL_FWD_EN undefined, run the distance-2 sequence → 2 stall cycles and fwd_sel always 00.
